// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised raster timing with sync, pixel flags and game tick.
//            Optional sync/active pipeline alignment via VGA_PIPE_ALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   HW       = 11,
    parameter int   VW       = 10,
    parameter int   TW       = 6
`ifdef VGA_PIPE_ALIGN_EN
    ,
    parameter int   PIPE_DLY = 2
`endif
) (
    input  logic          vclk,
    input  logic          rst,
    input  logic          freeze,
    input  logic [TW-1:0] tick_period,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          tick
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] c_h_last     = HW'(c_h_total - 1);
    localparam logic [HW-1:0] c_h_act      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] c_hs_first   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_hs_last    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] c_v_last     = VW'(c_v_total - 1);
    localparam logic [VW-1:0] c_v_act      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] c_vs_first   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_vs_last    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [TW-1:0] r_fc;

    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_tick;

    logic          w_hs;
    logic          w_vs;
    logic          w_act;
    logic          w_line;
    logic          w_frame;
    logic [TW:0]   w_period;
    logic [TW:0]   w_fc_next;
    logic          w_tick_due;

    always_ff @(posedge vclk) begin
        if (!rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_h_last) begin
            r_h <= '0;
            r_v <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_hs       = (r_h >= c_hs_first) && (r_h <= c_hs_last);
    assign w_vs       = (r_v >= c_vs_first) && (r_v <= c_vs_last);
    assign w_act      = (r_h < c_h_act) && (r_v < c_v_act);
    assign w_line     = (r_h == '0);
    assign w_frame    = w_line && (r_v == '0);

    // A period of zero behaves as one frame; the extra bit keeps fc+1 from wrapping.
    assign w_period   = (tick_period == '0) ? (TW+1)'(1) : {1'b0, tick_period};
    assign w_fc_next  = {1'b0, r_fc} + 1'b1;
    assign w_tick_due = (w_fc_next >= w_period);

    always_ff @(posedge vclk) begin
        if (!rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_tick        <= 1'b0;
            r_fc          <= '0;
        end else begin
            r_hcount      <= r_h;
            r_vcount      <= r_v;
            r_hsync       <= w_hs ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs ? VS_POL : ~VS_POL;
            r_active      <= w_act;
            r_line_start  <= w_line;
            r_frame_start <= w_frame;
            r_tick        <= 1'b0;
            if (w_frame && !freeze) begin
                if (w_tick_due) begin
                    r_tick <= 1'b1;
                    r_fc   <= '0;
                end else begin
                    r_fc   <= w_fc_next[TW-1:0];
                end
            end
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign tick        = r_tick;

`ifdef VGA_PIPE_ALIGN_EN
    // Sync pins and active trail hcount/vcount to match a PIPE_DLY-deep pixel pipeline.
    logic [2:0] r_pipe [PIPE_DLY];

    always_ff @(posedge vclk) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                r_pipe[i] <= {~HS_POL, ~VS_POL, 1'b0};
            end
        end else begin
            r_pipe[0] <= {r_hsync, r_vsync, r_active};
            for (int i = 1; i < PIPE_DLY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign hsync  = r_pipe[PIPE_DLY-1][2];
    assign vsync  = r_pipe[PIPE_DLY-1][1];
    assign active = r_pipe[PIPE_DLY-1][0];
`else
    assign hsync  = r_hsync;
    assign vsync  = r_vsync;
    assign active = r_active;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Scoreboard bench for vga_timing_gen on a 16x8 raster, both sync
//            polarities, tick period/freeze control and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int c_frame = 128;

    logic       vclk;
    logic       rst;
    logic       freeze;
    logic [5:0] tick_period;

    logic [3:0] hcount,  hcount_n;
    logic [2:0] vcount,  vcount_n;
    logic       hsync,   hsync_n;
    logic       vsync,   vsync_n;
    logic       active,  active_n;
    logic       line_start,  line_start_n;
    logic       frame_start, frame_start_n;
    logic       tick,    tick_n;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .HW(4), .VW(3), .TW(6)
    ) dut (
        .vclk(vclk), .rst(rst), .freeze(freeze), .tick_period(tick_period),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .active(active), .line_start(line_start), .frame_start(frame_start),
        .tick(tick)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .HW(4), .VW(3), .TW(6)
    ) dut_n (
        .vclk(vclk), .rst(rst), .freeze(freeze), .tick_period(tick_period),
        .hcount(hcount_n), .vcount(vcount_n), .hsync(hsync_n), .vsync(vsync_n),
        .active(active_n), .line_start(line_start_n), .frame_start(frame_start_n),
        .tick(tick_n)
    );

    initial begin
        vclk = 1'b0;
        forever #5 vclk = ~vclk;
    end

    typedef struct packed {
        logic [3:0] hc;
        logic [2:0] vc;
        logic       hs;
        logic       vs;
        logic       act;
        logic       ls;
        logic       fs;
        logic       tk;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_fs    = 0;
    int   n_tick  = 0;

    // Reference raster: 16 pixels per line, 8 lines, sync at h 10..11 and v 5.
    int   m_h  = 0;
    int   m_v  = 0;
    int   m_fc = 0;
`ifdef VGA_PIPE_ALIGN_EN
    logic [2:0] m_pipe [2];
`endif

    always @(posedge vclk) begin
        exp_t e;
        int   p;
        e = '0;
        if (!rst) begin
            m_h = 0; m_v = 0; m_fc = 0;
`ifdef VGA_PIPE_ALIGN_EN
            m_pipe[0] = 3'b000; m_pipe[1] = 3'b000;
`endif
        end else begin
            e.hc  = 4'(m_h);
            e.vc  = 3'(m_v);
            e.hs  = (m_h == 10 || m_h == 11);
            e.vs  = (m_v == 5);
            e.act = (m_h < 8) && (m_v < 4);
            e.ls  = (m_h == 0);
            e.fs  = (m_h == 0) && (m_v == 0);
            if (e.fs && !freeze) begin
                p = (tick_period == 0) ? 1 : int'(tick_period);
                if (m_fc + 1 >= p) begin
                    e.tk = 1'b1;
                    m_fc = 0;
                end else begin
                    m_fc = m_fc + 1;
                end
            end
`ifdef VGA_PIPE_ALIGN_EN
            begin
                logic [2:0] b;
                b = {e.hs, e.vs, e.act};
                {e.hs, e.vs, e.act} = m_pipe[1];
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = b;
            end
`endif
            m_h = m_h + 1;
            if (m_h == 16) begin
                m_h = 0;
                m_v = (m_v == 7) ? 0 : m_v + 1;
            end
        end
        sb.push_back(e);
    end

    int cyc     = 0;
    int last_fs = -1;

    always @(posedge vclk) begin
        exp_t e;
        #1;
        cyc++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_tests++;
            assert ({hcount, vcount} === {e.hc, e.vc}) else begin
                n_fail++;
                $error("FAIL pos got h=%0d v=%0d expected h=%0d v=%0d", hcount, vcount, e.hc, e.vc);
            end
            n_tests++;
            assert ({hsync, vsync} === {e.hs, e.vs}) else begin
                n_fail++;
                $error("FAIL sync at h=%0d v=%0d got %b%b expected %b%b", e.hc, e.vc, hsync, vsync, e.hs, e.vs);
            end
            n_tests++;
            assert ({hsync_n, vsync_n} === {~e.hs, ~e.vs}) else begin
                n_fail++;
                $error("FAIL sync_neg at h=%0d v=%0d got %b%b expected %b%b", e.hc, e.vc, hsync_n, vsync_n, ~e.hs, ~e.vs);
            end
            n_tests++;
            assert ({active, line_start, frame_start, tick} === {e.act, e.ls, e.fs, e.tk}) else begin
                n_fail++;
                $error("FAIL flags at h=%0d v=%0d got act/ls/fs/tk=%b%b%b%b expected %b%b%b%b", e.hc, e.vc,
                       active, line_start, frame_start, tick, e.act, e.ls, e.fs, e.tk);
            end
        end
        if (!rst) begin
            last_fs = -1;
        end else if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
                n_tests++;
                assert (cyc - last_fs == c_frame) else begin
                    n_fail++;
                    $error("FAIL frame_period got %0d expected %0d", cyc - last_fs, c_frame);
                end
            end
            last_fs = cyc;
        end
        if (frame_start === 1'b1) n_fs++;
        if (tick === 1'b1) n_tick++;
    end

    task automatic wait_fs(input int n);
        int target;
        int budget;
        target = n_fs + n;
        budget = n * c_frame + 300;
        while (n_fs < target && budget > 0) begin
            @(posedge vclk);
            #2;
            budget--;
        end
        n_tests++;
        assert (n_fs >= target) else begin
            n_fail++;
            $error("FAIL wait_fs timeout got %0d expected %0d", n_fs, target);
        end
    endtask

    task automatic check_ticks(input string tag, input int want);
        n_tests++;
        assert (n_tick === want) else begin
            n_fail++;
            $error("FAIL %s tick count got %0d expected %0d", tag, n_tick, want);
        end
    endtask

    initial begin
        int budget;
        rst         = 1'b0;
        freeze      = 1'b0;
        tick_period = 6'd3;
        repeat (4) @(negedge vclk);
        rst = 1'b1;

        wait_fs(9);
        check_ticks("period3", 3);

        // Freeze with fc=1, then expect the count to resume from 1.
        wait_fs(1);
        @(negedge vclk);
        freeze = 1'b1;
        wait_fs(4);
        check_ticks("frozen", 3);
        @(negedge vclk);
        freeze = 1'b0;
        wait_fs(1);
        check_ticks("resume_early", 3);
        wait_fs(1);
        check_ticks("resume", 4);

        @(negedge vclk);
        tick_period = 6'd5;
        wait_fs(3);
        check_ticks("period5", 4);
        @(negedge vclk);
        tick_period = 6'd1;
        wait_fs(1);
        check_ticks("lowered", 5);
        wait_fs(2);
        check_ticks("period1", 7);
        @(negedge vclk);
        tick_period = 6'd0;
        wait_fs(3);
        check_ticks("period0", 10);

        budget = 4 * c_frame;
        while (!(m_h == 5 && m_v == 2) && budget > 0) begin
            @(negedge vclk);
            budget--;
        end
        rst = 1'b0;
        @(posedge vclk);
        #2;
        n_tests++;
        assert ({hcount, vcount, hsync, vsync, hsync_n, vsync_n} === {4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1}) else begin
            n_fail++;
            $error("FAIL mid_reset got h=%0d v=%0d syncs=%b%b%b%b expected 0 0 0011",
                   hcount, vcount, hsync, vsync, hsync_n, vsync_n);
        end
        @(negedge vclk);
        rst = 1'b1;
        @(posedge vclk);
        #2;
        n_tests++;
        assert ({frame_start, active, hcount} === {1'b1, 1'b1, 4'd0}) else begin
            n_fail++;
            $error("FAIL fs_after_rst got fs=%b act=%b h=%0d expected 1 1 0", frame_start, active, hcount);
        end
        wait_fs(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
